// File: rtl/exception_unit_if.sv
// exception_unit_if
//   Bundles the control-unit side of the exception sequencer.
//   master : control unit / datapath (drives events, PC and memory data)
//   slave  : exception_unit (drives PC load, memory request, EPC/Cause/IE)
//   Signals:
//     ovf, bad_opcode, eret, ie_set, ie_clr : one-cycle event pulses
//     irq                                   : external interrupt level
//     instr_boundary                        : fetch cycle marker
//     pc_current, mem_rdata                 : datapath values
//     exc_active, exc_mem_req, exc_mem_addr : ownership of PC/memory
//     pc_load, pc_value                     : one-cycle PC write
//     epc, cause, ie                        : architectural state
//     dbg_state                             : current sequencer state
// Handshake: there is no ready path. exc_mem_req is a fixed-latency read
// request; memory must return data MEM_LAT cycles after the request starts,
// and the requester holds exc_mem_addr stable for the whole request.
interface exception_unit_if;
  logic        ovf;
  logic        bad_opcode;
  logic        irq;
  logic        instr_boundary;
  logic        eret;
  logic        ie_set;
  logic        ie_clr;
  logic [31:0] pc_current;
  logic [31:0] mem_rdata;
  logic        exc_active;
  logic        exc_mem_req;
  logic [31:0] exc_mem_addr;
  logic        pc_load;
  logic [31:0] pc_value;
  logic [31:0] epc;
  logic [31:0] cause;
  logic        ie;
  logic [1:0]  dbg_state;

  modport master (
    output ovf, bad_opcode, irq, instr_boundary, eret, ie_set, ie_clr,
           pc_current, mem_rdata,
    input  exc_active, exc_mem_req, exc_mem_addr, pc_load, pc_value,
           epc, cause, ie, dbg_state
  );

  modport slave (
    input  ovf, bad_opcode, irq, instr_boundary, eret, ie_set, ie_clr,
           pc_current, mem_rdata,
    output exc_active, exc_mem_req, exc_mem_addr, pc_load, pc_value,
           epc, cause, ie, dbg_state
  );
endinterface

// File: rtl/exception_unit.sv
// exception_unit
//   Exception / interrupt sequencer for the multicycle MIPS core. Captures
//   RI, overflow and interrupt events, saves EPC/Cause, reads the handler
//   address from a fixed vector word, then issues a one-cycle PC load.
//   eret reloads PC from EPC and re-enables interrupts.
//   Ports:
//     clock : rising-edge clock
//     reset : synchronous, active-low
//     bus   : exception_unit_if.slave (see interface header)
//   All outputs decode from registered state only.
module exception_unit #(
  parameter logic [31:0] VEC_IRQ = 32'h000000F4,
  parameter logic [31:0] VEC_RI  = 32'h000000F8,
  parameter logic [31:0] VEC_OVF = 32'h000000FC,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  exception_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    RET   = 2'd3
  } state_t;

  // Counter value of the final FETCH cycle (the one that captures data).
  localparam logic [2:0] LAT_LAST = 3'(MEM_LAT);

  state_t      state_q, state_d;
  logic [31:0] epc_q, epc_d;
  logic [4:0]  code_q, code_d;
  logic        df_q, df_d;
  logic        ie_q, ie_d;
  logic [31:0] vaddr_q, vaddr_d;
  logic [31:0] vec_q, vec_d;
  logic [2:0]  cnt_q, cnt_d;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      epc_q   <= 32'd0;
      code_q  <= 5'd0;
      df_q    <= 1'b0;
      ie_q    <= 1'b0;
      vaddr_q <= 32'd0;
      vec_q   <= 32'd0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      code_q  <= code_d;
      df_q    <= df_d;
      ie_q    <= ie_d;
      vaddr_q <= vaddr_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    code_d  = code_q;
    df_d    = df_q;
    ie_d    = ie_q;
    vaddr_d = vaddr_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.bad_opcode) begin
          // RI outranks a simultaneous overflow; EPC points at the
          // faulting instruction, PC has already advanced by 4.
          epc_d   = bus.pc_current - 32'd4;
          code_d  = 5'd10;
          vaddr_d = VEC_RI;
          ie_d    = 1'b0;
          cnt_d   = 3'd0;
          state_d = FETCH;
        end else if (bus.ovf) begin
          epc_d   = bus.pc_current - 32'd4;
          code_d  = 5'd12;
          vaddr_d = VEC_OVF;
          ie_d    = 1'b0;
          cnt_d   = 3'd0;
          state_d = FETCH;
        end else if (bus.irq && ie_q && bus.instr_boundary) begin
          // Taken before the PC increments, so resume at the same PC.
          epc_d   = bus.pc_current;
          code_d  = 5'd0;
          vaddr_d = VEC_IRQ;
          ie_d    = 1'b0;
          cnt_d   = 3'd0;
          state_d = FETCH;
        end else if (bus.eret) begin
          state_d = RET;
        end else if (bus.ie_clr) begin
          ie_d = 1'b0;
        end else if (bus.ie_set) begin
          ie_d = 1'b1;
        end
      end
      FETCH: begin
        if (cnt_q == LAT_LAST) begin
          vec_d   = bus.mem_rdata;
          state_d = LOAD;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      LOAD: begin
        state_d = IDLE;
      end
      RET: begin
        ie_d    = 1'b1;
        df_d    = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A fault while the sequencer is busy only marks a double fault.
    // Placed after the case so a fault in the RET cycle stays recorded.
    if ((state_q != IDLE) && (bus.ovf || bus.bad_opcode)) begin
      df_d = 1'b1;
    end
  end

  assign bus.exc_active   = (state_q != IDLE);
  assign bus.exc_mem_req  = (state_q == FETCH);
  assign bus.exc_mem_addr = (state_q == FETCH) ? vaddr_q : 32'd0;
  assign bus.pc_load      = (state_q == LOAD) || (state_q == RET);
  assign bus.pc_value     = (state_q == LOAD) ? vec_q :
                            (state_q == RET)  ? epc_q : 32'd0;
  assign bus.epc          = epc_q;
  assign bus.cause        = {df_q, 24'd0, code_q, 2'b00};
  assign bus.ie           = ie_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_exception_unit.sv
// tb_exception_unit
//   Bench for exception_unit: a vector table of single exceptions, hand
//   sequences for double fault / eret / mid-sequence reset / MEM_LAT=3, and a
//   randomized run checked against a transaction-level model of EPC, Cause
//   and IE.
module tb_exception_unit;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  exception_unit_if bus();
  exception_unit_if bus3();

  exception_unit dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  exception_unit #(.MEM_LAT(3)) dut3 (
    .clock (clock),
    .reset (reset),
    .bus   (bus3)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Architectural model
  logic [31:0] m_epc;
  logic [4:0]  m_code;
  logic        m_df;
  logic        m_ie;

  typedef struct {
    bit          f_ovf;
    bit          f_bad;
    bit          f_irq;
    logic [31:0] pc;
    logic [31:0] data;
    logic [31:0] exp_epc;
    logic [31:0] exp_cause;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] m_cause();
    return {m_df, 24'd0, m_code, 2'b00};
  endfunction

  task automatic clear_inputs;
    bus.ovf = 0; bus.bad_opcode = 0; bus.irq = 0; bus.instr_boundary = 0;
    bus.eret = 0; bus.ie_set = 0; bus.ie_clr = 0;
    bus.pc_current = 32'd0; bus.mem_rdata = 32'd0;
    bus3.ovf = 0; bus3.bad_opcode = 0; bus3.irq = 0; bus3.instr_boundary = 0;
    bus3.eret = 0; bus3.ie_set = 0; bus3.ie_clr = 0;
    bus3.pc_current = 32'd0; bus3.mem_rdata = 32'd0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_active"}, {31'd0, bus.exc_active}, 32'd0);
    chk({tag, "_memreq"}, {31'd0, bus.exc_mem_req}, 32'd0);
    chk({tag, "_addr"}, bus.exc_mem_addr, 32'd0);
    chk({tag, "_pcload"}, {31'd0, bus.pc_load}, 32'd0);
    chk({tag, "_pcvalue"}, bus.pc_value, 32'd0);
    chk({tag, "_epc"}, bus.epc, 32'd0);
    chk({tag, "_cause"}, bus.cause, 32'd0);
    chk({tag, "_ie"}, {31'd0, bus.ie}, 32'd0);
  endtask

  task automatic do_reset;
    clear_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    m_epc = 32'd0; m_code = 5'd0; m_df = 1'b0; m_ie = 1'b0;
    chk_all_zero("reset");
    chk("reset_active3", {31'd0, bus3.exc_active}, 32'd0);
  endtask

  // Drive one exception at cycle T and follow it to the first IDLE cycle.
  // inj raises ovf in the first FETCH cycle (double fault).
  task automatic do_exc(input bit f_ovf, input bit f_bad, input bit f_irq,
                        input logic [31:0] pc, input logic [31:0] data, input bit inj,
                        input logic [31:0] exp_epc, input logic [31:0] exp_cause,
                        input logic [31:0] exp_addr);
    int i;
    bus.ovf = f_ovf; bus.bad_opcode = f_bad; bus.irq = f_irq;
    bus.instr_boundary = 1'b1; bus.pc_current = pc; bus.mem_rdata = ~data;
    tick();
    bus.ovf = 0; bus.bad_opcode = 0; bus.irq = 0; bus.instr_boundary = 0;
    bus.pc_current = $urandom;
    chk("exc_active_t1", {31'd0, bus.exc_active}, 32'd1);
    chk("exc_epc", bus.epc, exp_epc);
    chk("exc_cause", bus.cause, exp_cause);
    chk("exc_ie", {31'd0, bus.ie}, 32'd0);
    i = 0;
    while (bus.exc_mem_req === 1'b1 && i < 20) begin
      chk("fetch_addr", bus.exc_mem_addr, exp_addr);
      chk("fetch_no_pcload", {31'd0, bus.pc_load}, 32'd0);
      // Only the last of the MEM_LAT+1 fetch cycles carries the vector.
      bus.mem_rdata = (i == 1) ? data : ~data;
      bus.ovf = inj && (i == 0);
      tick();
      i++;
    end
    bus.ovf = 0;
    chk("fetch_cycles", i, 32'd2);
    chk("load_pcload", {31'd0, bus.pc_load}, 32'd1);
    chk("load_pcvalue", bus.pc_value, data);
    chk("load_active", {31'd0, bus.exc_active}, 32'd1);
    tick();
    chk("post_pcload", {31'd0, bus.pc_load}, 32'd0);
    chk("post_active", {31'd0, bus.exc_active}, 32'd0);
    chk("post_epc", bus.epc, exp_epc);
    chk("post_cause", bus.cause, exp_cause | (inj ? 32'h80000000 : 32'd0));
  endtask

  // kind: 0 ovf, 1 ri, 2 ri+ovf together, 3 interrupt
  task automatic model_exc(input int kind, input bit inj);
    logic [31:0] pc, data, addr;
    bit f_ovf, f_bad, f_irq;
    pc    = $urandom & 32'hFFFF_FFFC;
    data  = $urandom;
    f_bad = (kind == 1) || (kind == 2);
    f_ovf = (kind == 0) || (kind == 2);
    f_irq = (kind == 3);
    if (f_bad) begin
      m_code = 5'd10; m_epc = pc - 32'd4; addr = 32'hF8;
    end else if (f_ovf) begin
      m_code = 5'd12; m_epc = pc - 32'd4; addr = 32'hFC;
    end else begin
      m_code = 5'd0; m_epc = pc; addr = 32'hF4;
    end
    m_ie = 1'b0;
    do_exc(f_ovf, f_bad, f_irq, pc, data, inj, m_epc, m_cause(), addr);
    if (inj) m_df = 1'b1;
  endtask

  task automatic do_eret;
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    chk("eret_pcload", {31'd0, bus.pc_load}, 32'd1);
    chk("eret_pcvalue", bus.pc_value, m_epc);
    chk("eret_active", {31'd0, bus.exc_active}, 32'd1);
    tick();
    m_ie = 1'b1;
    m_df = 1'b0;
    chk("eret_done_pcload", {31'd0, bus.pc_load}, 32'd0);
    chk("eret_done_active", {31'd0, bus.exc_active}, 32'd0);
    chk("eret_ie", {31'd0, bus.ie}, 32'd1);
    chk("eret_cause", bus.cause, m_cause());
  endtask

  task automatic do_ie(input bit s, input bit c);
    bus.ie_set = s; bus.ie_clr = c;
    tick();
    bus.ie_set = 0; bus.ie_clr = 0;
    if (c) m_ie = 1'b0;
    else if (s) m_ie = 1'b1;
    chk("ie_update", {31'd0, bus.ie}, {31'd0, m_ie});
  endtask

  // An interrupt that must not be taken (ie low or not at a boundary).
  task automatic irq_probe(input bit b);
    bus.irq = 1'b1; bus.instr_boundary = b; bus.pc_current = $urandom;
    tick();
    bus.irq = 1'b0; bus.instr_boundary = 1'b0;
    chk("irq_ignored", {31'd0, bus.exc_active}, 32'd0);
    chk("irq_epc_kept", bus.epc, m_epc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [31:0] d3;

    tbl[0] = '{1, 0, 0, 32'h00000040, 32'h00000200, 32'h0000003C, 32'h00000030, 32'h000000FC};
    tbl[1] = '{1, 1, 0, 32'h00000000, 32'h00001234, 32'hFFFFFFFC, 32'h00000028, 32'h000000F8};
    tbl[2] = '{0, 1, 0, 32'h00001000, 32'hCAFEF00C, 32'h00000FFC, 32'h00000028, 32'h000000F8};
    tbl[3] = '{0, 0, 1, 32'h00000080, 32'h00000180, 32'h00000080, 32'h00000000, 32'h000000F4};
    tbl[4] = '{1, 0, 0, 32'h00000004, 32'h00400000, 32'h00000000, 32'h00000030, 32'h000000FC};
    tbl[5] = '{0, 0, 1, 32'hFFFFFFFC, 32'h00000010, 32'hFFFFFFFC, 32'h00000000, 32'h000000F4};

    clear_inputs();
    reset = 1'b0;
    do_reset();

    // Vector table
    for (int k = 0; k < 6; k++) begin
      if (tbl[k].f_irq) do_ie(1'b1, 1'b0);
      do_exc(tbl[k].f_ovf, tbl[k].f_bad, tbl[k].f_irq, tbl[k].pc, tbl[k].data, 1'b0,
             tbl[k].exp_epc, tbl[k].exp_cause, tbl[k].exp_addr);
    end

    // Interrupt masking and ie_set/ie_clr priority
    do_reset();
    for (int k = 0; k < 4; k++) irq_probe(k[0]);
    do_ie(1'b1, 1'b0);
    irq_probe(1'b0);
    do_ie(1'b1, 1'b1);
    irq_probe(1'b1);

    // Double fault during FETCH, then eret
    do_reset();
    model_exc(0, 1'b1);
    do_eret();

    // Reset in the second FETCH cycle aborts the sequence
    do_reset();
    bus.ovf = 1'b1; bus.pc_current = 32'h40; bus.mem_rdata = 32'h200;
    tick();
    bus.ovf = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    m_epc = 32'd0; m_code = 5'd0; m_df = 1'b0; m_ie = 1'b0;
    chk_all_zero("abort");
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus.pc_load === 1'b1) cnt++;
      tick();
    end
    chk("abort_no_pcload", cnt, 32'd0);
    model_exc(0, 1'b0);

    // MEM_LAT = 3 instance
    d3 = 32'h0000_0300;
    bus3.ovf = 1'b1; bus3.pc_current = 32'h40; bus3.mem_rdata = ~d3;
    tick();
    bus3.ovf = 1'b0;
    cnt = 0;
    while (bus3.exc_mem_req === 1'b1 && cnt < 20) begin
      chk("lat3_addr", bus3.exc_mem_addr, 32'hFC);
      chk("lat3_no_pcload", {31'd0, bus3.pc_load}, 32'd0);
      bus3.mem_rdata = (cnt == 3) ? d3 : ~d3;
      tick();
      cnt++;
    end
    chk("lat3_fetch_cycles", cnt, 32'd4);
    chk("lat3_pcload", {31'd0, bus3.pc_load}, 32'd1);
    chk("lat3_pcvalue", bus3.pc_value, d3);
    tick();
    chk("lat3_idle", {31'd0, bus3.exc_active}, 32'd0);
    chk("lat3_epc", bus3.epc, 32'h3C);

    // Randomized run against the model
    do_reset();
    for (int k = 0; k < 60; k++) begin
      int r;
      r = $urandom_range(0, 6);
      case (r)
        0, 1, 2: model_exc(r, 1'($urandom_range(0, 1)));
        3: if (m_ie) model_exc(3, 1'($urandom_range(0, 1)));
           else irq_probe(1'b1);
        4: do_eret();
        5: do_ie(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        default: irq_probe(1'b0);
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
